// File: rtl/ysyx_22051013_hazard_ctrl.sv
// Pipeline hazard controller: a shift scoreboard of in-flight destinations that
// selects regfile/forwarding per source operand, stalls on load-use, and counts stalls.
module ysyx_22051013_hazard_ctrl #(
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 3,
    parameter  int CNT_W  = 32,
    localparam int FWD_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    output logic              id_kill_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              rs1_ena_i,
    input  logic              rs2_ena_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_ena_i,
    input  logic              is_load_i,
    input  logic              ex_busy_i,
    input  logic              flush_i,
    output logic [FWD_W-1:0]  fwd1_sel_o,
    output logic [FWD_W-1:0]  fwd2_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              ld;
    } slot_t;

    slot_t             slot_q [DEPTH];
    slot_t             slot0_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [FWD_W-1:0]  sel1_raw, sel2_raw;
    logic              load_use1, load_use2;
    logic              fire;

    // Scans oldest to youngest so the youngest match (lowest slot) overwrites.
    // Result is {load_use, sel}.
    function automatic logic [FWD_W:0] resolve(
        input logic              ena,
        input logic [ADDR_W-1:0] addr,
        input slot_t             slots [DEPTH]
    );
        logic [FWD_W-1:0] sel;
        logic             lu;
        sel = '0;
        lu  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ena && (addr != '0) && slots[k].v && (slots[k].rd == addr)) begin
                sel = FWD_W'(k + 1);
                lu  = (k == 0) && slots[k].ld;
            end
        end
        return {lu, sel};
    endfunction

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        {load_use1, sel1_raw} = resolve(rs1_ena_i, rs1_addr_i, slot_q);
        {load_use2, sel2_raw} = resolve(rs2_ena_i, rs2_addr_i, slot_q);
    end

    assign id_ready_o = ~rst & ~ex_busy_i & ~flush_i & ~load_use1 & ~load_use2;
    assign id_kill_o  = flush_i;
    assign fire       = id_valid_i & id_ready_o;
    assign fwd1_sel_o = (rst || load_use1) ? '0 : sel1_raw;
    assign fwd2_sel_o = (rst || load_use2) ? '0 : sel2_raw;

    // fire already excludes flush, so a killed instruction enters as a bubble.
    always_comb begin
        slot0_d = '0;
        if (fire) begin
            slot0_d.v  = rd_ena_i & (rd_addr_i != '0);
            slot0_d.rd = rd_addr_i;
            slot0_d.ld = is_load_i;
        end
    end

    // NOTE: the scoreboard is a handful of flops, so it is cleared by the async
    // reset like any other control state; no stale entry may survive reset.
    // NOTE: sequential state uses non-blocking assignments so the shift reads
    // the pre-edge value of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else if (!ex_busy_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                slot_q[k] <= slot_q[k-1];
            end
            slot_q[0] <= slot0_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (id_valid_i && !id_ready_o && !flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22051013_hazard_ctrl.sv
// Directed bench for ysyx_22051013_hazard_ctrl: forwarding, load-use, busy hold,
// flush, async reset and counter saturation (second instance with CNT_W=4).
module tb_ysyx_22051013_hazard_ctrl;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int FWD_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid_i;
    logic [ADDR_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic              rs1_ena_i, rs2_ena_i, rd_ena_i, is_load_i;
    logic              ex_busy_i, flush_i;

    logic              id_ready_o, id_kill_o;
    logic [FWD_W-1:0]  fwd1_sel_o, fwd2_sel_o;
    logic [31:0]       stall_cnt_o;

    logic              s_ready, s_kill;
    logic [FWD_W-1:0]  s_fwd1, s_fwd2;
    logic [3:0]        s_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ysyx_22051013_hazard_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_kill_o(id_kill_o), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_ena_i(rs1_ena_i), .rs2_ena_i(rs2_ena_i), .rd_addr_i(rd_addr_i),
        .rd_ena_i(rd_ena_i), .is_load_i(is_load_i), .ex_busy_i(ex_busy_i),
        .flush_i(flush_i), .fwd1_sel_o(fwd1_sel_o), .fwd2_sel_o(fwd2_sel_o),
        .stall_cnt_o(stall_cnt_o)
    );

    ysyx_22051013_hazard_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(s_ready),
        .id_kill_o(s_kill), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_ena_i(rs1_ena_i), .rs2_ena_i(rs2_ena_i), .rd_addr_i(rd_addr_i),
        .rd_ena_i(rd_ena_i), .is_load_i(is_load_i), .ex_busy_i(ex_busy_i),
        .flush_i(flush_i), .fwd1_sel_o(s_fwd1), .fwd2_sel_o(s_fwd2),
        .stall_cnt_o(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rd, input logic wr, input logic ld,
                         input logic [ADDR_W-1:0] r1, input logic e1,
                         input logic [ADDR_W-1:0] r2, input logic e2);
        id_valid_i = 1'b1;
        rd_addr_i  = rd;  rd_ena_i  = wr; is_load_i = ld;
        rs1_addr_i = r1;  rs1_ena_i = e1;
        rs2_addr_i = r2;  rs2_ena_i = e2;
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid_i = 1'b0; ex_busy_i = 1'b0; flush_i = 1'b1;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
        rs1_ena_i = 1'b0; rs2_ena_i = 1'b0; rd_ena_i = 1'b0; is_load_i = 1'b0;

        // Reset state
        tick();
        check("rst_ready", id_ready_o, 0);
        check("rst_kill_follows_flush", id_kill_o, 1);
        check("rst_cnt", stall_cnt_o, 0);
        flush_i = 1'b0;
        rs1_addr_i = 5'd1; rs1_ena_i = 1'b1;
        #1;
        check("rst_fwd1", fwd1_sel_o, 0);
        tick();
        rst = 1'b0;
        #1;

        // Back-to-back ALU: add x5; sub x6, x5, x5
        issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
        check("alu_first_ready", id_ready_o, 1);
        tick();
        issue(5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
        check("alu_fwd1", fwd1_sel_o, 1);
        check("alu_fwd2", fwd2_sel_o, 1);
        check("alu_ready", id_ready_o, 1);
        tick();
        check("alu_no_stall", stall_cnt_o, 0);

        // Load-use: lw x7; add x8, x7 -> one stall, then sel=2
        issue(5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
        tick();
        issue(5'd8, 1, 0, 5'd7, 1, 5'd0, 0);
        check("lu_ready", id_ready_o, 0);
        check("lu_fwd1_zero", fwd1_sel_o, 0);
        tick();
        check("lu_cnt", stall_cnt_o, 1);
        check("lu_after_ready", id_ready_o, 1);
        check("lu_after_fwd1", fwd1_sel_o, 2);
        tick();

        // Youngest wins: x3 at slots 2 and 0 with an x0 write between
        issue(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        issue(5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        issue(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        id_valid_i = 1'b0;
        rs1_addr_i = 5'd3; rs1_ena_i = 1'b1;
        rs2_addr_i = 5'd0; rs2_ena_i = 1'b1;
        #1;
        check("young_fwd1", fwd1_sel_o, 1);
        check("x0_fwd2", fwd2_sel_o, 0);
        rs1_ena_i = 1'b0;
        #1;
        check("disabled_rs1", fwd1_sel_o, 0);

        // Busy hold for 4 cycles with a valid instruction waiting
        issue(5'd9, 1, 0, 5'd3, 1, 5'd0, 0);
        ex_busy_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("busy_ready", id_ready_o, 0);
            tick();
        end
        check("busy_cnt", stall_cnt_o, 5);
        ex_busy_i = 1'b0;
        #1;
        check("busy_release_fwd1", fwd1_sel_o, 1);
        check("busy_release_ready", id_ready_o, 1);
        tick();

        // Flush: x10 killed, x9 now in slot 1
        issue(5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
        flush_i = 1'b1;
        #1;
        check("flush_kill", id_kill_o, 1);
        check("flush_ready", id_ready_o, 0);
        tick();
        flush_i = 1'b0;
        id_valid_i = 1'b0;
        rs1_addr_i = 5'd10; rs1_ena_i = 1'b1;
        rs2_addr_i = 5'd9;  rs2_ena_i = 1'b1;
        #1;
        check("flush_cnt", stall_cnt_o, 5);
        check("flush_killed_rd", fwd1_sel_o, 0);
        check("flush_kept_slot1", fwd2_sel_o, 2);

        // Flush together with busy: kill still follows, counter unchanged
        id_valid_i = 1'b1; flush_i = 1'b1; ex_busy_i = 1'b1;
        #1;
        check("flushbusy_kill", id_kill_o, 1);
        tick();
        check("flushbusy_cnt", stall_cnt_o, 5);
        check("flushbusy_hold", fwd2_sel_o, 2);
        flush_i = 1'b0; ex_busy_i = 1'b0;

        // Fill three slots: x11 (WB), x12, x13
        issue(5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        issue(5'd12, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        issue(5'd13, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        id_valid_i = 1'b0;
        rs1_addr_i = 5'd11; rs1_ena_i = 1'b1;
        rs2_addr_i = 5'd12; rs2_ena_i = 1'b1;
        #1;
        check("wb_fwd1", fwd1_sel_o, 3);
        check("ls_fwd2", fwd2_sel_o, 2);

        // Async reset between edges
        #1;
        rst = 1'b1;
        #1;
        check("arst_cnt", stall_cnt_o, 0);
        check("arst_fwd1", fwd1_sel_o, 0);
        check("arst_ready", id_ready_o, 0);
        rst = 1'b0;
        #1;
        check("arst_cleared_fwd1", fwd1_sel_o, 0);
        check("arst_cleared_fwd2", fwd2_sel_o, 0);
        check("arst_release_ready", id_ready_o, 1);

        // Saturation: 20 stalled cycles under busy
        tick();
        id_valid_i = 1'b1; ex_busy_i = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("sat_cnt4_14", s_cnt, 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_cnt4", s_cnt, 15);
        check("sat_cnt32", stall_cnt_o, 20);
        check("sat_ready4", s_ready, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_hazard_ctrl.md
# ysyx_22051013_hazard_ctrl

Parametrised pipeline hazard controller for the pipelined successor of the single-cycle `ysyx_22051013` core. It sits beside the IDU and tracks every in-flight destination register from issue (EX) to retirement (WB) in a DEPTH-entry scoreboard shift pipeline. From that state it decides, per source operand of the instruction in ID, whether to read the regfile, forward from a later stage, or stall. It also handles multi-cycle EXU back-pressure, branch flush and a stall performance counter.

## Interface
- ADDR_W, 5, register address width (2^ADDR_W architectural registers; x0 hard-wired).
- DEPTH, 3, tracked stages after ID: slot 0 = EX, slot 1 = LS, slot DEPTH-1 = WB; legal range 2..8.
- CNT_W, 32, stall counter width.
- FWD_W, $clog2(DEPTH+1), forward-select width (derived, not overridable).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID holds a valid instruction wanting issue.
- id_ready_o  out  1  issue accepted this cycle (fire = id_valid_i & id_ready_o).
- id_kill_o  out  1  instruction in ID is squashed; equals flush_i.
- rs1_addr_i / rs2_addr_i  in  ADDR_W  source registers of ID instruction.
- rs1_ena_i / rs2_ena_i  in  1  source actually read.
- rd_addr_i  in  ADDR_W  destination of ID instruction.
- rd_ena_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load (result available only after LS).
- ex_busy_i  in  1  EXU multi-cycle operation in progress; freezes pipeline.
- flush_i  in  1  taken branch/jump resolved in EX this cycle.
- fwd1_sel_o / fwd2_sel_o  out  FWD_W  0 = regfile; k+1 = forward from slot k.
- stall_cnt_o  out  CNT_W  saturating count of stalled issue cycles.

## Operation
- Scoreboard: DEPTH entries {v, rd, ld}. Entry written only with v=1 when rd_ena_i=1 and rd_addr_i!=0; otherwise v=0 (bubble).
- Advance (ex_busy_i=0): slot[k+1] <= slot[k] for k=0..DEPTH-2; slot[DEPTH-1] retires. slot[0] <= fire & ~flush_i ? {rd_ena_i&(rd_addr_i!=0), rd_addr_i, is_load_i} : bubble.
- Hold (ex_busy_i=1): all slots keep their values; id_ready_o=0.
- Operand match: operand n with rsn_ena_i=1 and rsn_addr_i!=0 matches slot k when slot[k].v and slot[k].rd==rsn_addr_i. The youngest match (lowest k) wins; older matches are ignored.
- Forward select: no match -> 0; match at k -> k+1. A match at slot 0 with ld=1 is a load-use hazard; fwdn_sel_o is then don't-care, driven 0.
- id_ready_o = ~rst & ~ex_busy_i & ~flush_i & ~load_use1 & ~load_use2. A disabled operand never causes a hazard.
- A load-use stall lasts exactly one cycle: the load moves to slot 1 and the next cycle forwards with sel=2.
- Flush: id_kill_o=flush_i. The instruction in ID is not issued, and a bubble enters slot 0. Entries already in slots (including the branch itself) are kept.
- Flush and busy together: busy wins for slot movement (hold). id_kill_o still follows flush_i.
- Stall counter: increments when id_valid_i & ~id_ready_o & ~flush_i. It holds at 2^CNT_W-1 (no wrap).

## Timing
- fwd*_sel_o, id_ready_o and id_kill_o are combinational from inputs and current slots: zero-cycle decision.
- An issued instruction is visible in slot 0 the cycle after fire and reaches slot k after k+1 non-busy cycles. It stops being tracked after DEPTH non-busy cycles.
- Reset (asserted any time, including mid-stall or while busy): all slots v=0 immediately and stall_cnt_o=0. During reset id_ready_o=0, fwd*_sel_o=0 and id_kill_o=flush_i.
- First fire is possible in the first cycle after rst deasserts.
- WB-stage forwarding (slot DEPTH-1) covers the same-cycle regfile write/read; the regfile needs no internal bypass.

## Test plan
- Back-to-back ALU: issue `add x5`, then `sub` reading x5 and x5 -> cycle 2 fwd1_sel_o=1, fwd2_sel_o=1, id_ready_o=1, no stall.
- Load-use: issue `lw x7`, then `add` reading rs1=x7 -> one cycle with id_ready_o=0 and stall_cnt_o 0->1. Next cycle id_ready_o=1, fwd1_sel_o=2.
- Youngest wins and x0: x3 is written at slots 2 and 0, rs1=x3 -> fwd1_sel_o=1. rs2=x0 while a slot holds rd=0 with rd_ena -> fwd2_sel_o=0.
- Busy hold: hold ex_busy_i=1 for 4 cycles with id_valid_i=1 -> slots frozen, id_ready_o=0, stall_cnt_o +4. On release the forwarding selects are unchanged from before.
- Flush: flush_i=1 with id_valid_i=1 -> id_kill_o=1, no issue, bubble into slot 0, stall_cnt_o unchanged. A later reader of the killed rd gets sel=0.
- Async reset mid-operation: assert rst between clock edges with 3 valid slots -> slots cleared and stall_cnt_o=0 without waiting for a clock edge. After release every fwd*_sel_o=0. Saturation check with CNT_W=4 stalled 20 cycles -> stall_cnt_o=15.
